// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and writeback formatting for the 5-stage RV32I
//   core. Captures memory-stage results, extracts and extends load data,
//   selects the final result and drives the register-file write port. The
//   writeback value (wb_write_data) doubles as the EX-stage forwarding source.
//
//   Optional feature: define WB_INSTRET_EN to add the 64-bit retired
//   instruction counter output wb_instret.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall, flush      hold / invalidate stage contents (flush has priority)
//   m_valid           MEM stage holds a valid instruction
//   m_reg_write, m_rd destination write enable and register
//   m_result_src      00=ALU, 01=load, 10=PC+4, 11=immediate
//   m_funct3          load size/sign (RV32I encoding)
//   m_alu_result      ALU result; bits [1:0] are the load byte offset
//   m_pc_plus4        PC+4 for JAL/JALR
//   m_imm             U-type immediate
//   m_mem_rdata       raw aligned word from data memory
//   wb_valid          stage holds a valid instruction
//   wb_reg_write      register-file write enable (never set for x0)
//   wb_rd             register-file write address (0 when invalid)
//   wb_write_data     formatted write data (0 when invalid)
//   wb_instret        retired instruction count (WB_INSTRET_EN only)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            m_valid,
   input  logic            m_reg_write,
   input  logic [4:0]      m_rd,
   input  logic [1:0]      m_result_src,
   input  logic [2:0]      m_funct3,
   input  logic [XLEN-1:0] m_alu_result,
   input  logic [XLEN-1:0] m_pc_plus4,
   input  logic [XLEN-1:0] m_imm,
   input  logic [XLEN-1:0] m_mem_rdata,
   output logic            wb_valid,
   output logic            wb_reg_write,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_write_data
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]     wb_instret
`endif
);

   logic            valid_q,      valid_d;
   logic            reg_write_q,  reg_write_d;
   logic [4:0]      rd_q,         rd_d;
   logic [1:0]      result_src_q, result_src_d;
   logic [2:0]      funct3_q,     funct3_d;
   logic [1:0]      offset_q,     offset_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
   logic [XLEN-1:0] imm_q,        imm_d;
   logic [XLEN-1:0] mem_rdata_q,  mem_rdata_d;

   // Next-state: flush only clears valid; the stale fields are masked by
   // valid on every output, so they never reach the register file.
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      rd_d         = rd_q;
      result_src_d = result_src_q;
      funct3_d     = funct3_q;
      offset_d     = offset_q;
      alu_result_d = alu_result_q;
      pc_plus4_d   = pc_plus4_q;
      imm_d        = imm_q;
      mem_rdata_d  = mem_rdata_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d      = m_valid;
         reg_write_d  = m_reg_write;
         rd_d         = m_rd;
         result_src_d = m_result_src;
         funct3_d     = m_funct3;
         offset_d     = m_alu_result[1:0];
         alu_result_d = m_alu_result;
         pc_plus4_d   = m_pc_plus4;
         imm_d        = m_imm;
         mem_rdata_d  = m_mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         result_src_q <= '0;
         funct3_q     <= '0;
         offset_q     <= '0;
         alu_result_q <= '0;
         pc_plus4_q   <= '0;
         imm_q        <= '0;
         mem_rdata_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         rd_q         <= rd_d;
         result_src_q <= result_src_d;
         funct3_q     <= funct3_d;
         offset_q     <= offset_d;
         alu_result_q <= alu_result_d;
         pc_plus4_q   <= pc_plus4_d;
         imm_q        <= imm_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   // Load formatting from registered fields only (no input-to-output path).
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] result;

   always_comb begin
      case (offset_q)
         2'd0:    load_byte = mem_rdata_q[7:0];
         2'd1:    load_byte = mem_rdata_q[15:8];
         2'd2:    load_byte = mem_rdata_q[23:16];
         default: load_byte = mem_rdata_q[31:24];
      endcase
      load_half = offset_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];

      case (funct3_q)
         3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
         3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
         default: load_data = mem_rdata_q;
      endcase

      case (result_src_q)
         2'b00:   result = alu_result_q;
         2'b01:   result = load_data;
         2'b10:   result = pc_plus4_q;
         default: result = imm_q;
      endcase
   end

   always_comb begin
      wb_valid      = valid_q;
      wb_reg_write  = valid_q & reg_write_q & (rd_q != 5'd0);
      wb_rd         = valid_q ? rd_q : 5'd0;
      wb_write_data = valid_q ? result : '0;
   end

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   // Counts the held instruction on the edge it leaves the stage, so a
   // stalled instruction is counted exactly once and a flushed one never.
   always_comb begin
      instret_d = instret_q + 64'(valid_q & ~stall & ~flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign wb_instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_reg_write = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [1:0]  m_result_src = '0;
   logic [2:0]  m_funct3 = '0;
   logic [31:0] m_alu_result = '0;
   logic [31:0] m_pc_plus4 = '0;
   logic [31:0] m_imm = '0;
   logic [31:0] m_mem_rdata = '0;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
`ifdef WB_INSTRET_EN
   logic [63:0] wb_instret;
`endif

   int total = 0;
   int bad = 0;

   // Reference model: what the register file should see from the held instruction.
   logic        e_valid = 1'b0;
   logic        e_we = 1'b0;
   logic [4:0]  e_rd = '0;
   logic [31:0] e_data = '0;
   logic [63:0] e_instret = '0;

   mem_wb_stage #(.XLEN(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .m_valid       (m_valid),
      .m_reg_write   (m_reg_write),
      .m_rd          (m_rd),
      .m_result_src  (m_result_src),
      .m_funct3      (m_funct3),
      .m_alu_result  (m_alu_result),
      .m_pc_plus4    (m_pc_plus4),
      .m_imm         (m_imm),
      .m_mem_rdata   (m_mem_rdata),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_write_data (wb_write_data)
`ifdef WB_INSTRET_EN
      ,
      .wb_instret    (wb_instret)
`endif
   );

   always #5 clk = ~clk;

   // Load/result semantics with plain arithmetic on the architectural rules.
   function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] pc4,
                                              input logic [31:0] imm, input logic [31:0] rdata);
      longint r, v;
      int off;
      logic [63:0] bits;
      if (src == 2'd0) return alu;
      if (src == 2'd2) return pc4;
      if (src == 2'd3) return imm;
      r   = longint'({32'd0, rdata});
      off = int'(alu % 4);
      case (f3)
         3'd0: begin v = (r / (longint'(1) << (8 * off))) % 256; if (v >= 128) v = v - 256; end
         3'd4: v = (r / (longint'(1) << (8 * off))) % 256;
         3'd1: begin v = (r / (longint'(1) << (16 * (off / 2)))) % 65536; if (v >= 32768) v = v - 65536; end
         3'd5: v = (r / (longint'(1) << (16 * (off / 2)))) % 65536;
         default: v = r;
      endcase
      bits = 64'(v);
      return bits[31:0];
   endfunction

   task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] imm, input logic [31:0] rdata,
                        input logic st, input logic fl);
      m_valid = v; m_reg_write = we; m_rd = rd; m_result_src = src; m_funct3 = f3;
      m_alu_result = alu; m_pc_plus4 = pc4; m_imm = imm; m_mem_rdata = rdata;
      stall = st; flush = fl;
   endtask

   // Advance one clock: update the model from the inputs present at the edge.
   task automatic tick();
      if (rst_n) begin
         if (e_valid && !stall && !flush) e_instret = e_instret + 64'd1;
         if (flush) begin
            e_valid = 1'b0; e_we = 1'b0; e_rd = '0; e_data = '0;
         end else if (!stall) begin
            e_valid = m_valid;
            e_we    = m_valid && m_reg_write && (m_rd != 5'd0);
            e_rd    = m_valid ? m_rd : 5'd0;
            e_data  = m_valid ? ref_result(m_result_src, m_funct3, m_alu_result,
                                           m_pc_plus4, m_imm, m_mem_rdata) : 32'd0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      e_valid = 1'b0; e_we = 1'b0; e_rd = '0; e_data = '0; e_instret = '0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({wb_valid, wb_reg_write, wb_rd, wb_write_data} !== 39'd0) begin
         bad++; $display("FAIL reset_init got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_write, wb_rd, wb_write_data);
      end
      @(negedge clk) rst_n = 1'b1;
      drive(1, 1, 5'd9, 2'd0, 3'd0, 32'hCAFE_0001, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_reg_write !== 1'b1 || wb_write_data !== 32'hCAFE_0001) begin
         bad++; $display("FAIL reset_pre_write got=%b/%h exp=1/cafe0001", wb_reg_write, wb_write_data);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (wb_reg_write !== 1'b0 || wb_write_data !== 32'd0 || wb_valid !== 1'b0 || wb_rd !== 5'd0) begin
         bad++; $display("FAIL reset_async got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_write, wb_rd, wb_write_data);
      end
      tick();
      tick();
      total++;
      if ({wb_valid, wb_reg_write, wb_rd, wb_write_data} !== 39'd0) begin
         bad++; $display("FAIL reset_held got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_write, wb_rd, wb_write_data);
      end
      rst_n = 1'b1;
      #2;
      total++;
      if ({wb_valid, wb_reg_write, wb_rd, wb_write_data} !== 39'd0) begin
         bad++; $display("FAIL reset_release got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_write, wb_rd, wb_write_data);
      end
   endtask

   task automatic test_alu();
      drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_write_data !== 32'h1234_5678 || wb_valid !== 1'b1) begin
         bad++; $display("FAIL alu_rd5 got=%b/%0d/%h exp=1/5/12345678", wb_reg_write, wb_rd, wb_write_data);
      end
      drive(1, 1, 5'd0, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
         bad++; $display("FAIL alu_rd0 got=we%b valid%b exp=we0 valid1", wb_reg_write, wb_valid);
      end
   endtask

   task automatic test_load();
      logic [2:0]  f3s  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [31:0] offs [6] = '{32'h1000, 32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001};
      logic [31:0] exps [6] = '{32'h0000_0002, 32'hFFFF_FF80, 32'h0000_0080,
                                32'hFFFF_80F1, 32'h0000_80F1, 32'h80F1_7F02};
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 5'd10, 2'd1, f3s[i], offs[i], 32'd0, 32'd0, 32'h80F1_7F02, 0, 0);
         tick();
         total++;
         if (wb_write_data !== exps[i] || wb_write_data !== e_data) begin
            bad++; $display("FAIL load_%0d got=%h exp=%h", i, wb_write_data, exps[i]);
         end
      end
   endtask

   task automatic test_jal_lui();
      drive(1, 1, 5'd1, 2'd2, 3'd0, 32'h5555_5555, 32'h0000_0104, 32'hABCD_E000, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_write_data !== 32'h0000_0104) begin
         bad++; $display("FAIL jal got=%h exp=00000104", wb_write_data);
      end
      drive(1, 1, 5'd2, 2'd3, 3'd0, 32'h5555_5555, 32'h0000_0104, 32'hABCD_E000, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_write_data !== 32'hABCD_E000) begin
         bad++; $display("FAIL lui got=%h exp=abcde000", wb_write_data);
      end
   endtask

   task automatic test_stall_flush();
      drive(1, 1, 5'd7, 2'd0, 3'd0, 32'h55, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 5'(20 + i), 2'd0, 3'd0, $urandom, 32'd0, 32'd0, 32'd0, 1, 0);
         tick();
         total++;
         if (wb_rd !== 5'd7 || wb_write_data !== 32'h55 || wb_reg_write !== 1'b1) begin
            bad++; $display("FAIL stall_hold_%0d got=%0d/%h exp=7/00000055", i, wb_rd, wb_write_data);
         end
      end
      drive(1, 1, 5'd8, 2'd0, 3'd0, 32'h66, 32'd0, 32'd0, 32'd0, 1, 1);
      tick();
      total++;
      if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_write_data !== 32'd0) begin
         bad++; $display("FAIL stall_flush got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_write, wb_rd, wb_write_data);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 5'(i + 11), 2'd0, 3'd0, 32'h100 + 32'(i), 32'd0, 32'd0, 32'd0, 0, 0);
         tick();
         total++;
         if (wb_rd !== 5'(i + 11) || wb_write_data !== 32'h100 + 32'(i) || wb_reg_write !== 1'b1) begin
            bad++; $display("FAIL b2b_%0d got=%0d/%h exp=%0d/%h", i, wb_rd, wb_write_data, i + 11, 32'h100 + 32'(i));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 31)),
               2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
         tick();
         total++;
         if (wb_valid !== e_valid || wb_reg_write !== e_we || wb_rd !== e_rd || wb_write_data !== e_data) begin
            bad++; $display("FAIL random_%0d got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", i,
                            wb_valid, wb_reg_write, wb_rd, wb_write_data, e_valid, e_we, e_rd, e_data);
         end
`ifdef WB_INSTRET_EN
         total++;
         if (wb_instret !== e_instret) begin
            bad++; $display("FAIL random_instret_%0d got=%0d exp=%0d", i, wb_instret, e_instret);
         end
`endif
      end
   endtask

`ifdef WB_INSTRET_EN
   task automatic test_instret();
      logic [2:0] seq [15] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b100, 3'b000, 3'b001,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
      @(negedge clk) rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         drive(seq[i][2], 1, 5'd3, 2'd0, 3'd0, 32'(i), 32'd0, 32'd0, 32'd0, seq[i][1], seq[i][0]);
         tick();
      end
      total++;
      if (wb_instret !== 64'd10 || e_instret !== 64'd10) begin
         bad++; $display("FAIL instret_count got=%0d exp=10", wb_instret);
      end
      @(negedge clk);
      force dut.instret_q = '1;
      #1 release dut.instret_q;
      e_instret = '1;
      drive(1, 1, 5'd3, 2'd0, 3'd0, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      drive(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
      tick();
      total++;
      if (wb_instret !== 64'd0 || e_instret !== 64'd0) begin
         bad++; $display("FAIL instret_wrap got=%h exp=0", wb_instret);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_jal_lui();
      test_stall_flush();
      test_back_to_back();
      test_random();
`ifdef WB_INSTRET_EN
      test_instret();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatting for the 5-stage RV32I core.
- Sits directly upstream of the register file. Captures memory-stage results and formats load data (byte/half extraction, sign/zero extension).
- Selects the final result and drives the register file write port (reg_write, rd, write_data).
- Also exports the writeback value for EX-stage forwarding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the stage contents.
- flush  input  1  invalidate the stage contents.
- m_valid  input  1  MEM stage holds a valid instruction.
- m_reg_write  input  1  instruction writes rd.
- m_rd  input  5  destination register.
- m_result_src  input  2  00=ALU, 01=load, 10=PC+4, 11=immediate (LUI).
- m_funct3  input  3  load size/sign (RV32I encoding).
- m_alu_result  input  XLEN  ALU result; bits [1:0] give the load byte offset.
- m_pc_plus4  input  XLEN  PC+4 for JAL/JALR.
- m_imm  input  XLEN  U-type immediate.
- m_mem_rdata  input  XLEN  raw aligned word from data memory.
- wb_valid  output  1  stage holds a valid instruction.
- wb_reg_write  output  1  write enable to register file.
- wb_rd  output  5  write address to register file.
- wb_write_data  output  XLEN  formatted write data.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every stage register to 0.
  - While reset is held: wb_valid=0, wb_reg_write=0, wb_rd=0, wb_write_data=0.
  - A reset asserted mid-operation drops wb_reg_write in the same cycle, with no clock edge required.
- Register update on each posedge clk with rst_n high, in priority order:
  1. flush=1: valid cleared; other fields don't-care but must not reach wb_reg_write.
  2. else stall=1: all fields hold.
  3. else: capture m_valid, m_reg_write, m_rd, m_result_src, m_funct3, m_alu_result[1:0] (offset), m_alu_result, m_pc_plus4, m_imm, m_mem_rdata.
  - flush and stall asserted together: flush wins.
- Latency: exactly 1 cycle from MEM inputs to wb_* outputs. All wb_* outputs are combinational from stage registers only; no input-to-output combinational path.
- wb_reg_write = valid & reg_write & (rd != 0). An rd=0 write is suppressed here, so wb_reg_write never asserts for x0.
- wb_rd = registered rd when valid, else 0.
- Load formatting (result_src=01) uses registered offset and funct3:
  - 000 LB: byte lane offset[1:0], sign-extended.
  - 100 LBU: same lane, zero-extended.
  - 001 LH: halfword lane offset[1] (offset[0] ignored), sign-extended.
  - 101 LHU: same lane, zero-extended.
  - 010 LW: full word, offset ignored.
  - 011/110/111: full word, unmodified.
  - Byte lanes are little-endian: lane 0 = bits [7:0].
- Result select:
  - 00: alu_result
  - 01: formatted load
  - 10: pc_plus4
  - 11: imm
- wb_write_data = selected result when valid, else 0.
- Back-to-back operation: a new instruction is accepted every cycle when stall=0; no bubbles are inserted by the block.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined:
  - Adds output wb_instret (64 bits): count of instructions retired.
  - Increments by 1 on each posedge where the stage holds a valid instruction, stall=0 and flush=0.
  - Wraps modulo 2^64.
  - Cleared by rst_n.
  - A stalled instruction counts exactly once.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: drive rst_n=0 mid-stream with a valid write pending → wb_reg_write=0, wb_write_data=0 immediately, before any clock edge; all outputs stay 0 until the first capture after rst_n=1.
- ALU path: m_valid=1, m_reg_write=1, m_rd=5, src=00, alu=0x12345678 → next cycle wb_reg_write=1, wb_rd=5, wb_write_data=0x12345678. Same instruction with m_rd=0 → wb_reg_write=0.
- Load formatting: mem_rdata=0x80F1_7F02, then:
  - LB offset 0 → 0x00000002
  - LB offset 3 → 0xFFFFFF80
  - LBU offset 3 → 0x00000080
  - LH offset 2 → 0xFFFF80F1
  - LHU offset 2 → 0x000080F1
  - LW → 0x80F17F02
- JAL/LUI: src=10, pc_plus4=0x00000104 → wb_write_data=0x00000104; src=11, imm=0xABCDE000 → 0xABCDE000.
- Stall/flush: capture rd=7/0x55; hold stall=1 for 3 cycles while inputs change → outputs stay rd=7/0x55. Then assert stall=1 and flush=1 together → next cycle wb_valid=0, wb_reg_write=0.
- WB_INSTRET_EN: 10 valid instructions with 2 stall cycles and 1 flush interleaved → wb_instret=10. Preload the counter to 2^64-1 (force), retire 1 → wb_instret=0.
